// File: rtl/color_detect_pkg.sv
// Shared definitions for the color-detect control block.
//   - Color bin indices (red .. white) in datapath order
//   - Host register map bases: ctrl1 (hue) at 0..5, ctrl2 (sat/val) at 6..11
//   - Commit FSM state encoding
//   - Default widths for the hue, sat/val and result-cell registers
package color_detect_pkg;

  localparam int unsigned COLOR_RED    = 0;
  localparam int unsigned COLOR_ORANGE = 1;
  localparam int unsigned COLOR_YELLOW = 2;
  localparam int unsigned COLOR_GREEN  = 3;
  localparam int unsigned COLOR_BLUE   = 4;
  localparam int unsigned COLOR_WHITE  = 5;

  localparam int unsigned NUM_COLORS_DEF = COLOR_WHITE + 1;
  localparam int unsigned HUE_W_DEF      = 16;
  localparam int unsigned SV_W_DEF       = 32;
  localparam int unsigned NUM_CELLS_DEF  = 9;
  localparam int unsigned CELL_W_DEF     = 3;

  localparam logic [3:0] ADDR_CTRL1_BASE = 4'd0;
  localparam logic [3:0] ADDR_CTRL2_BASE = 4'd6;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StPending = 2'd1;
  localparam logic [1:0] StApply   = 2'd2;

endpackage

// File: rtl/color_detect_ctrl_if.sv
// Host/datapath/consumer signal bundle for color_detect_ctrl.
//   slave  : the controller side (takes writes, commits, frame pulses, results)
//   master : the host/datapath/consumer side
// Optional macro COLOR_CTRL_READBACK_EN adds i_rd_addr, i_rd_src and o_rd_data.
interface color_detect_ctrl_if
  import color_detect_pkg::*;
#(
  parameter int unsigned NUM_COLORS = NUM_COLORS_DEF,
  parameter int unsigned HUE_W      = HUE_W_DEF,
  parameter int unsigned SV_W       = SV_W_DEF,
  parameter int unsigned NUM_CELLS  = NUM_CELLS_DEF,
  parameter int unsigned CELL_W     = CELL_W_DEF
);

  logic                         i_wr_en;
  logic [3:0]                   i_wr_addr;
  logic [SV_W-1:0]              i_wr_data;
  logic                         i_commit;
  logic                         o_busy;
  logic [7:0]                   o_cfg_epoch;
  logic                         i_frame_start;
  logic                         i_frame_done;
  logic [NUM_COLORS*HUE_W-1:0]  o_hue_ctrl;
  logic [NUM_COLORS*SV_W-1:0]   o_sv_ctrl;
  logic [NUM_CELLS*CELL_W-1:0]  i_colors;
  logic [NUM_CELLS*CELL_W-1:0]  o_res_data;
  logic                         o_res_valid;
  logic                         i_res_ready;
  logic                         o_res_overflow;
`ifdef COLOR_CTRL_READBACK_EN
  logic [3:0]                   i_rd_addr;
  logic                         i_rd_src;
  logic [SV_W-1:0]              o_rd_data;
`endif

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_commit, i_frame_start, i_frame_done,
    input  i_colors, i_res_ready,
    output o_busy, o_cfg_epoch, o_hue_ctrl, o_sv_ctrl, o_res_data, o_res_valid,
    output o_res_overflow
`ifdef COLOR_CTRL_READBACK_EN
    , input i_rd_addr, i_rd_src
    , output o_rd_data
`endif
  );

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_commit, i_frame_start, i_frame_done,
    output i_colors, i_res_ready,
    input  o_busy, o_cfg_epoch, o_hue_ctrl, o_sv_ctrl, o_res_data, o_res_valid,
    input  o_res_overflow
`ifdef COLOR_CTRL_READBACK_EN
    , output i_rd_addr, i_rd_src
    , input o_rd_data
`endif
  );

endinterface

// File: rtl/color_result_skid.sv
// Per-frame result capture with a one-entry valid/ready output stage.
// Ports:
//   i_clk, i_rstn    clock, asynchronous active-low reset
//   i_frame_done     pulse: i_colors is final for this frame
//   i_colors         datapath result cells
//   i_res_ready      consumer accepts o_res_data this cycle
//   o_res_data       held result
//   o_res_valid      o_res_data is available
//   o_res_overflow   sticky: a frame result was dropped because the stage was full
module color_result_skid #(
  parameter int unsigned NUM_CELLS = 9,
  parameter int unsigned CELL_W    = 3
) (
  input  logic                        i_clk,
  input  logic                        i_rstn,
  input  logic                        i_frame_done,
  input  logic [NUM_CELLS*CELL_W-1:0] i_colors,
  input  logic                        i_res_ready,
  output logic [NUM_CELLS*CELL_W-1:0] o_res_data,
  output logic                        o_res_valid,
  output logic                        o_res_overflow
);

  logic [NUM_CELLS*CELL_W-1:0] data_q;
  logic                        valid_q;
  logic                        overflow_q;
  logic                        slot_free;

  // The slot can take a new result if empty or being drained this cycle.
  assign slot_free = !valid_q || i_res_ready;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (i_frame_done && slot_free) begin
        data_q  <= i_colors;
        valid_q <= 1'b1;
      end else if (valid_q && i_res_ready) begin
        valid_q <= 1'b0;
      end
      if (i_frame_done && !slot_free) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign o_res_data     = data_q;
  assign o_res_valid    = valid_q;
  assign o_res_overflow = overflow_q;

endmodule

// File: rtl/color_detect_ctrl.sv
// Configuration and result-handshake controller for the color-detect datapath.
// Host writes land in shadow registers; a commit copies them into the active
// registers only on the cycle after the next frame start, so thresholds never
// change mid-frame. Frame results are captured by color_result_skid.
// Ports:
//   i_clk, i_rstn  clock, asynchronous active-low reset
//   bus            color_detect_ctrl_if.slave: register writes, commit/busy/epoch,
//                  frame pulses, active hue/sat-val outputs, result handshake
// Optional macro COLOR_CTRL_READBACK_EN: registered readback of shadow or active
// registers through bus.i_rd_addr / bus.i_rd_src / bus.o_rd_data.
module color_detect_ctrl
  import color_detect_pkg::*;
#(
  parameter int unsigned NUM_COLORS = NUM_COLORS_DEF,
  parameter int unsigned HUE_W      = HUE_W_DEF,
  parameter int unsigned SV_W       = SV_W_DEF,
  parameter int unsigned NUM_CELLS  = NUM_CELLS_DEF,
  parameter int unsigned CELL_W     = CELL_W_DEF
) (
  input logic                i_clk,
  input logic                i_rstn,
  color_detect_ctrl_if.slave bus
);

  localparam int unsigned HueVecW = NUM_COLORS * HUE_W;
  localparam int unsigned SvVecW  = NUM_COLORS * SV_W;

  logic [HueVecW-1:0] hue_sh_q, hue_sh_d, hue_act_q;
  logic [SvVecW-1:0]  sv_sh_q, sv_sh_d, sv_act_q;
  logic [1:0]         state_q, state_d;
  logic [7:0]         epoch_q;

  // Shadow writes; addresses beyond the ctrl2 range match nothing.
  always_comb begin
    hue_sh_d = hue_sh_q;
    sv_sh_d  = sv_sh_q;
    for (int c = 0; c < NUM_COLORS; c++) begin
      if (bus.i_wr_en && bus.i_wr_addr == 4'(ADDR_CTRL1_BASE + c)) begin
        hue_sh_d[c*HUE_W +: HUE_W] = bus.i_wr_data[HUE_W-1:0];
      end
      if (bus.i_wr_en && bus.i_wr_addr == 4'(ADDR_CTRL2_BASE + c)) begin
        sv_sh_d[c*SV_W +: SV_W] = bus.i_wr_data;
      end
    end
  end

  // Commit FSM: a commit arriving with a frame start in IDLE only arms;
  // commits while armed or applying are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (bus.i_commit)      state_d = StPending;
      StPending: if (bus.i_frame_start) state_d = StApply;
      StApply:                          state_d = StIdle;
      default:                          state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hue_sh_q  <= '0;
      sv_sh_q   <= '0;
      hue_act_q <= '0;
      sv_act_q  <= '0;
      state_q   <= StIdle;
      epoch_q   <= 8'd0;
    end else begin
      hue_sh_q <= hue_sh_d;
      sv_sh_q  <= sv_sh_d;
      state_q  <= state_d;
      // Copies the pre-write shadow value when a write coincides with APPLY.
      if (state_q == StApply) begin
        hue_act_q <= hue_sh_q;
        sv_act_q  <= sv_sh_q;
        epoch_q   <= epoch_q + 8'd1;
      end
    end
  end

  assign bus.o_busy      = (state_q != StIdle);
  assign bus.o_cfg_epoch = epoch_q;
  assign bus.o_hue_ctrl  = hue_act_q;
  assign bus.o_sv_ctrl   = sv_act_q;

  color_result_skid #(
    .NUM_CELLS (NUM_CELLS),
    .CELL_W    (CELL_W)
  ) u_result_skid (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_frame_done   (bus.i_frame_done),
    .i_colors       (bus.i_colors),
    .i_res_ready    (bus.i_res_ready),
    .o_res_data     (bus.o_res_data),
    .o_res_valid    (bus.o_res_valid),
    .o_res_overflow (bus.o_res_overflow)
  );

`ifdef COLOR_CTRL_READBACK_EN
  logic [SV_W-1:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < NUM_COLORS; c++) begin
      if (bus.i_rd_addr == 4'(ADDR_CTRL1_BASE + c)) begin
        rd_data_d = SV_W'(bus.i_rd_src ? hue_act_q[c*HUE_W +: HUE_W]
                                       : hue_sh_q[c*HUE_W +: HUE_W]);
      end
      if (bus.i_rd_addr == 4'(ADDR_CTRL2_BASE + c)) begin
        rd_data_d = bus.i_rd_src ? sv_act_q[c*SV_W +: SV_W] : sv_sh_q[c*SV_W +: SV_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.o_rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_color_detect_ctrl.sv
module tb_color_detect_ctrl;
  import color_detect_pkg::*;

  localparam int unsigned NC = 6;
  localparam int unsigned HW = 16;
  localparam int unsigned SW = 32;
  localparam int unsigned NCELL = 9;
  localparam int unsigned CW = 3;
  localparam int unsigned RW = NCELL * CW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  color_detect_ctrl_if #(
    .NUM_COLORS(NC), .HUE_W(HW), .SV_W(SW), .NUM_CELLS(NCELL), .CELL_W(CW)
  ) bus ();

  color_detect_ctrl #(
    .NUM_COLORS(NC), .HUE_W(HW), .SV_W(SW), .NUM_CELLS(NCELL), .CELL_W(CW)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  int total = 0;
  int bad = 0;

  // Reference model: register files plus a commit that waits for a frame start
  // and then lands one clock later.
  logic [HW-1:0] m_hue_sh[NC];
  logic [HW-1:0] m_hue_act[NC];
  logic [SW-1:0] m_sv_sh[NC];
  logic [SW-1:0] m_sv_act[NC];
  bit            m_waiting;
  bit            m_applying;
  logic [7:0]    m_epoch;
  logic          m_valid;
  logic          m_ovf;
  logic [RW-1:0] m_data;

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_hue_sh[c] = '0; m_hue_act[c] = '0; m_sv_sh[c] = '0; m_sv_act[c] = '0;
    end
    m_waiting = 0; m_applying = 0; m_epoch = 8'd0;
    m_valid = 1'b0; m_ovf = 1'b0; m_data = '0;
  endtask

  task automatic model_edge();
    int a;
    bit next_applying;
    if (m_applying) begin
      for (int c = 0; c < NC; c++) begin
        m_hue_act[c] = m_hue_sh[c];
        m_sv_act[c]  = m_sv_sh[c];
      end
      m_epoch = m_epoch + 8'd1;
    end
    if (bus.i_wr_en) begin
      a = int'(bus.i_wr_addr);
      if (a < NC) m_hue_sh[a] = bus.i_wr_data[HW-1:0];
      else if (a < 2 * NC) m_sv_sh[a-NC] = bus.i_wr_data;
    end
    next_applying = m_waiting && bus.i_frame_start;
    if (m_waiting) m_waiting = !bus.i_frame_start;
    else m_waiting = !m_applying && bus.i_commit;
    m_applying = next_applying;
    if (bus.i_frame_done) begin
      if (!m_valid || bus.i_res_ready) begin
        m_data = bus.i_colors;
        m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (m_valid && bus.i_res_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NC*HW-1:0] eh;
    logic [NC*SW-1:0] es;
    for (int c = 0; c < NC; c++) begin
      eh[c*HW +: HW] = m_hue_act[c];
      es[c*SW +: SW] = m_sv_act[c];
    end
    check({tag, ".busy"}, 192'(bus.o_busy), 192'(m_waiting || m_applying));
    check({tag, ".epoch"}, 192'(bus.o_cfg_epoch), 192'(m_epoch));
    check({tag, ".hue"}, 192'(bus.o_hue_ctrl), 192'(eh));
    check({tag, ".sv"}, 192'(bus.o_sv_ctrl), es);
    check({tag, ".valid"}, 192'(bus.o_res_valid), 192'(m_valid));
    check({tag, ".data"}, 192'(bus.o_res_data), 192'(m_data));
    check({tag, ".ovf"}, 192'(bus.o_res_overflow), 192'(m_ovf));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic clear_inputs();
    bus.i_wr_en = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
    bus.i_commit = 1'b0; bus.i_frame_start = 1'b0; bus.i_frame_done = 1'b0;
    bus.i_colors = '0; bus.i_res_ready = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    clear_inputs();
    rstn = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    check({tag, ".busy0"}, 192'(bus.o_busy), 192'(0));
    check({tag, ".valid0"}, 192'(bus.o_res_valid), 192'(0));
    check({tag, ".epoch0"}, 192'(bus.o_cfg_epoch), 192'(0));
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [SW-1:0] data);
    bus.i_wr_en = 1'b1; bus.i_wr_addr = addr; bus.i_wr_data = data;
    cycle("wr");
    bus.i_wr_en = 1'b0;
  endtask

  initial begin
    model_reset();
    clear_inputs();
    #2;
    do_reset("reset");

    // Basic commit applied at the next frame start.
    wr(4'(COLOR_RED), 32'h0000_1234);
    wr(4'(ADDR_CTRL2_BASE + COLOR_RED), 32'hAABB_CCDD);
    bus.i_commit = 1'b1;
    cycle("commit");
    bus.i_commit = 1'b0;
    check("busy_pending", 192'(bus.o_busy), 192'(1));
    for (int i = 0; i < 3; i++) cycle("pend");
    bus.i_frame_start = 1'b1;
    cycle("fstart");
    bus.i_frame_start = 1'b0;
    check("busy_apply", 192'(bus.o_busy), 192'(1));
    check("hue_before_apply", 192'(bus.o_hue_ctrl[15:0]), 192'(0));
    cycle("applied");
    check("hue0", 192'(bus.o_hue_ctrl[15:0]), 192'(16'h1234));
    check("sv0", 192'(bus.o_sv_ctrl[31:0]), 192'(32'hAABB_CCDD));
    check("epoch1", 192'(bus.o_cfg_epoch), 192'(1));
    check("busy_idle", 192'(bus.o_busy), 192'(0));

    // Long wait with no frame start; a second commit is not queued.
    wr(4'(COLOR_RED), 32'h0000_5555);
    bus.i_commit = 1'b1;
    cycle("commit2");
    bus.i_commit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.i_commit = (i == 50);
      cycle("wait");
    end
    bus.i_commit = 1'b0;
    check("busy_held", 192'(bus.o_busy), 192'(1));
    check("hue_unchanged", 192'(bus.o_hue_ctrl[15:0]), 192'(16'h1234));
    check("epoch_still1", 192'(bus.o_cfg_epoch), 192'(1));
    bus.i_frame_start = 1'b1;
    cycle("fstart2");
    bus.i_frame_start = 1'b0;
    cycle("applied2");
    cycle("idle2");
    check("epoch2", 192'(bus.o_cfg_epoch), 192'(2));
    check("hue_5555", 192'(bus.o_hue_ctrl[15:0]), 192'(16'h5555));

    // Write to ctrl1[3] coincident with APPLY keeps the old active value.
    bus.i_commit = 1'b1;
    cycle("commit3");
    bus.i_commit = 1'b0;
    bus.i_frame_start = 1'b1;
    cycle("fstart3");
    bus.i_frame_start = 1'b0;
    wr(4'(COLOR_GREEN), 32'h0000_BEEF);
    check("hue3_old", 192'(bus.o_hue_ctrl[COLOR_GREEN*HW +: HW]), 192'(0));
    check("epoch3", 192'(bus.o_cfg_epoch), 192'(3));
    bus.i_commit = 1'b1;
    cycle("commit4");
    bus.i_commit = 1'b0;
    bus.i_frame_start = 1'b1;
    cycle("fstart4");
    bus.i_frame_start = 1'b0;
    cycle("applied4");
    check("hue3_new", 192'(bus.o_hue_ctrl[COLOR_GREEN*HW +: HW]), 192'(16'hBEEF));
    check("epoch4", 192'(bus.o_cfg_epoch), 192'(4));

    // Back-to-back frame results with ready held high.
    bus.i_res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [RW-1:0] col;
      col = RW'(32'h0111_1111 * (k + 1));
      bus.i_frame_done = 1'b1;
      bus.i_colors = col;
      cycle("b2b");
      check("b2b_valid", 192'(bus.o_res_valid), 192'(1));
      check("b2b_data", 192'(bus.o_res_data), 192'(col));
      check("b2b_ovf", 192'(bus.o_res_overflow), 192'(0));
    end
    bus.i_frame_done = 1'b0;
    cycle("drain");
    check("drained", 192'(bus.o_res_valid), 192'(0));

    // Stalled consumer: second result dropped, overflow sticky.
    bus.i_res_ready = 1'b0;
    bus.i_frame_done = 1'b1;
    bus.i_colors = 27'h5A5A5A5;
    cycle("fd1");
    check("res_valid", 192'(bus.o_res_valid), 192'(1));
    check("res_data", 192'(bus.o_res_data), 192'(27'h5A5A5A5));
    bus.i_colors = 27'h1234567;
    cycle("fd2");
    bus.i_frame_done = 1'b0;
    check("ovf_set", 192'(bus.o_res_overflow), 192'(1));
    check("data_held", 192'(bus.o_res_data), 192'(27'h5A5A5A5));
    cycle("hold");
    check("ovf_sticky", 192'(bus.o_res_overflow), 192'(1));

    // Reset while a commit is pending and a result is held.
    bus.i_commit = 1'b1;
    cycle("commit5");
    bus.i_commit = 1'b0;
    check("pending_before_rst", 192'(bus.o_busy), 192'(1));
    do_reset("midreset");
    check("rst_ovf0", 192'(bus.o_res_overflow), 192'(0));
    check("rst_hue0", 192'(bus.o_hue_ctrl), 192'(0));
    bus.i_frame_start = 1'b1;
    cycle("fs_after_rst");
    bus.i_frame_start = 1'b0;
    cycle("after_rst1");
    cycle("after_rst2");
    check("no_apply_epoch", 192'(bus.o_cfg_epoch), 192'(0));
    check("no_apply_busy", 192'(bus.o_busy), 192'(0));

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.i_wr_en = ($urandom % 3) == 0;
      bus.i_wr_addr = 4'($urandom);
      bus.i_wr_data = $urandom;
      bus.i_commit = ($urandom % 8) == 0;
      bus.i_frame_start = ($urandom % 6) == 0;
      bus.i_frame_done = ($urandom % 4) == 0;
      bus.i_res_ready = ($urandom % 2) == 0;
      bus.i_colors = RW'($urandom);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/color_detect_ctrl.md
Name: color_detect_ctrl

Overview:
- Configuration and result-handshake controller for the color-detect datapath (RGB to HSV conversion plus color binning).
- Host writes hue and sat/val thresholds into shadow registers. A commit request transfers them to the active registers only at the next frame start, so thresholds never change mid-frame.
- Per-frame color results (nine 3-bit codes) are captured at frame end and presented to a consumer over a valid/ready handshake, with overflow detection.

Parameters:
- NUM_COLORS, 6, number of color bins (red, orange, yellow, green, blue, white, in that index order)
- HUE_W, 16, width of each hue control register (ctrl1)
- SV_W, 32, width of each sat/val control register (ctrl2)
- NUM_CELLS, 9, number of result cells
- CELL_W, 3, width of each result code

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  asynchronous active-low reset
- i_wr_en  in  1  host register write strobe
- i_wr_addr  in  4  register index: 0..5 = ctrl1[color], 6..11 = ctrl2[color], 12..15 ignored
- i_wr_data  in  SV_W  write data; ctrl1 takes bits [HUE_W-1:0]
- i_commit  in  1  request to apply shadow registers at next frame start
- o_busy  out  1  commit pending
- o_cfg_epoch  out  8  count of applied commits, wraps at 255 to 0
- i_frame_start  in  1  single-cycle pulse, first pixel of frame entering datapath
- i_frame_done  in  1  single-cycle pulse, datapath results for frame final
- o_hue_ctrl  out  NUM_COLORS*HUE_W  active ctrl1 registers, packed, color 0 in LSBs
- o_sv_ctrl  out  NUM_COLORS*SV_W  active ctrl2 registers, packed, color 0 in LSBs
- i_colors  in  NUM_CELLS*CELL_W  datapath results, cell 0 in LSBs
- o_res_data  out  NUM_CELLS*CELL_W  captured results
- o_res_valid  out  1  captured result available
- i_res_ready  in  1  consumer accepts result
- o_res_overflow  out  1  sticky: a frame result was dropped

Behaviour:
- Reset values: all outputs, shadow registers, active registers, o_cfg_epoch, o_res_data and flags are 0. State is IDLE.
- Shadow write:
  - When i_wr_en=1 and addr ≤ 11, the shadow register updates on the next edge.
  - Addresses 12..15 have no effect.
  - Writes are accepted in every state.
- FSM states:
  - IDLE: i_commit=1 goes to PENDING.
  - PENDING: i_frame_start=1 goes to APPLY.
  - APPLY: lasts one cycle. Active registers take the shadow values, o_cfg_epoch increments, then the FSM returns to IDLE.
- o_busy=1 in PENDING and APPLY.
- i_commit in PENDING or APPLY is ignored. No queuing.
- i_commit and i_frame_start in the same cycle while in IDLE: go to PENDING only. Apply happens at the following frame start.
- Shadow write in the same cycle as APPLY: active registers take the pre-write shadow value. The write still lands in shadow.
- Active registers are updated in APPLY only. Outputs are registered and valid on the cycle after APPLY.
- Result capture:
  - i_frame_done=1 with o_res_valid=0: o_res_data <= i_colors and o_res_valid <= 1 on the next edge.
  - A transfer occurs when o_res_valid && i_res_ready. o_res_valid clears on the next edge unless i_frame_done=1 in the same cycle; then new data is loaded and o_res_valid stays 1.
  - i_frame_done=1 while o_res_valid=1 and i_res_ready=0: the new result is dropped, old data is held, and o_res_overflow is set (sticky until reset).
- Async reset mid-operation: a pending commit is discarded and any held result is lost.

Optional Feature:
- COLOR_CTRL_READBACK_EN
- Defined: adds ports i_rd_addr (4 bits), i_rd_src (1 bit: 0 = shadow, 1 = active) and o_rd_data (SV_W bits).
  - o_rd_data is registered with 1-cycle latency.
  - ctrl1 entries are zero-extended.
  - Addresses 12..15 return 0.
- Undefined: the ports are absent and no readback logic is generated.

Decomposition:
- Shared package color_detect_pkg holds:
  - color index constants (COLOR_RED=0 .. COLOR_WHITE=5) and register address constants
  - the FSM state encoding (IDLE, PENDING, APPLY)
  - the HUE_W / SV_W / CELL_W defaults
- One natural sub-module: color_result_skid, the result capture/handshake/overflow logic.

Test Plan:
- Reset, then write addr 0 = 0x00001234 and addr 6 = 0xAABBCCDD, commit, pulse frame_start → o_busy=1 until APPLY, then o_hue_ctrl[15:0]=0x1234, o_sv_ctrl[31:0]=0xAABBCCDD, o_cfg_epoch=1.
- Commit with no frame_start for 100 cycles → active registers unchanged, o_busy held 1. A second commit during PENDING leaves o_cfg_epoch incrementing only once.
- Write addr 3 in the APPLY cycle → active keeps the old value. Next commit plus frame_start applies the new value.
- frame_done with i_colors=27'h5A5A5A5 and ready=0 → o_res_valid=1, data held. A second frame_done → o_res_overflow=1, data unchanged.
- ready=1 held, frame_done on consecutive cycles → each result appears for one cycle, valid continuous, no overflow.
- Assert i_rstn low during PENDING with o_res_valid=1 → all outputs 0. A frame_start after release applies nothing.
